jk_count_sequencer: RTL and testbench

//  Command-driven sequencer for a bank of WIDTH jk_ff cells forming a modulo-MODULUS counter.

---
 rtl/jk_seq_pkg.sv | 24 ++
 rtl/jk_count_sequencer_if.sv | 25 ++
 rtl/jk_count_sequencer_excite.sv | 25 ++
 rtl/jk_ff.sv | 25 ++
 rtl/jk_count_sequencer.sv | 145 ++++++++++++++
 tb/tb_jk_count_sequencer.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK counter sequencer: command opcodes, FSM states
// and the J/K excitation encodings.
package jk_seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_STOP  = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_e;

  // {J,K} pairs
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_count_sequencer_if.sv
// Command handshake and status bundle between the control logic (master)
// and the counter sequencer (slave).
interface jk_count_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, count, busy, tc, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, count, busy, tc, done, cmd_err
  );
endinterface

// File: rtl/jk_count_sequencer_excite.sv
// Per-bit J/K excitation: toggle the bits that differ between the present and
// the wanted next count, hold the rest.
module jk_excite
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] next,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [1:0] jk_bit;

    always_comb begin
      jk_bit = (q[gi] != next[gi]) ? JK_TOGGLE : JK_HOLD;
    end

    assign j[gi] = jk_bit[1];
    assign k[gi] = jk_bit[0];
  end

endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jk_ff
  import jk_seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:  q <= q;
        JK_RESET: q <= 1'b0;
        JK_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_count_sequencer.sv
// Command-driven modulo-MODULUS counter built on a bank of jk_ff cells; the
// controller decides the next count and jk_excite turns it into J/K drives.
module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  jk_count_sequencer_if.slave   bus
);

  localparam logic [WIDTH:0] MOD_W = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             ready_q;
  logic             busy_q, tc_q, tc_d, done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0] count_w, next_val, j_vec, k_vec;
  logic [WIDTH:0]   cnt_ext, up_ext, dn_ext, data_ext;
  logic [WIDTH-1:0] up_val, down_val, load_val, step_val;
  logic             up_wrap, down_wrap, go_up, step_wrap, accept;

  // Extra top bit lets MODULUS == 2**WIDTH and the down-borrow be detected.
  always_comb begin
    cnt_ext   = {1'b0, count_w};
    data_ext  = {1'b0, bus.cmd_data};
    up_ext    = cnt_ext + 1'b1;
    dn_ext    = cnt_ext - 1'b1;
    up_wrap   = (up_ext == MOD_W);
    down_wrap = dn_ext[WIDTH];
    up_val    = up_wrap ? '0 : up_ext[WIDTH-1:0];
    down_val  = down_wrap ? MAX_W[WIDTH-1:0] : dn_ext[WIDTH-1:0];
    load_val  = (data_ext > MAX_W) ? MAX_W[WIDTH-1:0] : bus.cmd_data;
    go_up     = (state_q == IDLE) ? (bus.cmd_op == OP_UP) : (state_q == RUN_UP);
    step_val  = go_up ? up_val : down_val;
    step_wrap = go_up ? up_wrap : down_wrap;
    accept    = bus.cmd_valid & ready_q;
  end

  always_comb begin
    next_val = count_w;
    state_d  = state_q;
    steps_d  = steps_q;
    tc_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_CLEAR: next_val = '0;
            OP_LOAD:  next_val = load_val;
            OP_UP, OP_DOWN: begin
              if (bus.cmd_data == '0) begin
                done_d = 1'b1;
              end else begin
                // The first step is taken on the accepting edge itself.
                next_val = step_val;
                tc_d     = step_wrap;
                steps_d  = bus.cmd_data - 1'b1;
                if (bus.cmd_data == WIDTH'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = (bus.cmd_op == OP_UP) ? RUN_UP : RUN_DOWN;
                end
              end
            end
            OP_NOP, OP_STOP: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      default: begin
        if (accept && bus.cmd_op == OP_STOP) begin
          state_d = IDLE;
          steps_d = '0;
          done_d  = 1'b1;
        end else if (accept && bus.cmd_op == OP_CLEAR) begin
          next_val = '0;
          state_d  = IDLE;
          steps_d  = '0;
          done_d   = 1'b1;
        end else begin
          err_d    = accept && (bus.cmd_op != OP_NOP);
          next_val = step_val;
          tc_d     = step_wrap;
          steps_d  = steps_q - 1'b1;
          if (steps_q == WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      steps_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      ready_q <= 1'b1;
      busy_q  <= (state_d != IDLE);
      tc_q    <= tc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q    (count_w),
    .next (next_val),
    .j    (j_vec),
    .k    (k_vec)
  );

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_ff u_ff (
      .clock (clock),
      .reset (reset),
      .j     (j_vec[gi]),
      .k     (k_vec[gi]),
      .q     (count_w[gi])
    );
  end

  assign bus.count     = count_w;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.tc        = tc_q;
  assign bus.done      = done_q;
  assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Randomized and directed check of jk_count_sequencer against an arithmetic
// model of the counter, plus a per-cycle J/K excitation check.
module tb_jk_count_sequencer;
  import jk_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  jk_count_sequencer_if #(.WIDTH(WIDTH)) bus ();

  jk_count_sequencer #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: current value, steps left in the run, direction, last-edge pulses.
  int m_cnt, m_rem, m_up, m_tc, m_done, m_err, m_rdy;

  bit               exc_en   = 1'b0;
  bit               have_prev = 1'b0;
  bit               prev_rst;
  logic [WIDTH-1:0] prev_j, prev_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (m_up != 0) begin
      m_tc  = (m_cnt == MOD - 1);
      m_cnt = (m_cnt + 1) % MOD;
    end else begin
      m_tc  = (m_cnt == 0);
      m_cnt = (m_cnt + MOD - 1) % MOD;
    end
    m_rem--;
    if (m_rem == 0) m_done = 1;
  endtask

  task automatic model_edge(input bit rst, input bit v, input int op, input int data);
    bit acc;
    if (rst) begin
      m_cnt = 0; m_rem = 0; m_tc = 0; m_done = 0; m_err = 0; m_rdy = 0;
      return;
    end
    acc    = v && (m_rdy != 0);
    m_rdy  = 1;
    m_tc   = 0; m_done = 0; m_err = 0;
    if (m_rem == 0) begin
      if (acc) begin
        case (op)
          1: m_cnt = 0;
          2: m_cnt = (data >= MOD) ? MOD - 1 : data;
          3, 4: begin
            if (data == 0) m_done = 1;
            else begin
              m_up  = (op == 3);
              m_rem = data;
              model_step();
            end
          end
          0, 5: ;
          default: m_err = 1;
        endcase
      end
    end else if (acc && op == 5) begin
      m_rem = 0; m_done = 1;
    end else if (acc && op == 1) begin
      m_cnt = 0; m_rem = 0; m_done = 1;
    end else begin
      if (acc && op != 0) m_err = 1;
      model_step();
    end
  endtask

  task automatic apply(input bit rst, input bit v, input int op, input int data);
    reset         = rst;
    bus.cmd_valid = v;
    bus.cmd_op    = op[2:0];
    bus.cmd_data  = data[WIDTH-1:0];
    @(posedge clock);
    model_edge(rst, v, op, data);
    #1;
    check_eq("count", 32'(bus.count), m_cnt);
    check_eq("busy", 32'(bus.busy), 32'(m_rem != 0));
    check_eq("tc", 32'(bus.tc), m_tc);
    check_eq("done", 32'(bus.done), m_done);
    check_eq("cmd_err", 32'(bus.cmd_err), m_err);
    check_eq("cmd_ready", 32'(bus.cmd_ready), m_rdy);
  endtask

  task automatic cmd(input int op, input int data);
    apply(1'b0, 1'b1, op, data);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 0, 0);
  endtask

  // J/K pairs must be HOLD or TOGGLE, and TOGGLE exactly where the bit flips.
  always @(negedge clock) begin
    if (exc_en) begin
      if (have_prev && !prev_rst)
        check_eq("jk_toggle", 32'(prev_j), 32'(prev_cnt ^ bus.count));
      check_eq("jk_form", 32'(dut.k_vec), 32'(dut.j_vec));
      prev_j    = dut.j_vec;
      prev_cnt  = bus.count;
      prev_rst  = reset;
      have_prev = 1'b1;
    end
  end

  initial begin
    int exp_cnt[4];
    int exp_tc[4];
    int exp_done[4];
    exp_cnt  = '{9, 0, 1, 2};
    exp_tc   = '{0, 1, 0, 0};
    exp_done = '{0, 0, 0, 1};
    m_up = 1;

    apply(1'b1, 1'b0, 0, 0);
    apply(1'b1, 1'b0, 0, 0);
    exc_en = 1'b1;
    check_eq("rst_count", 32'(bus.count), 0);
    idle();
    check_eq("ready_after_rst", 32'(bus.cmd_ready), 1);

    // Reset in the middle of UP 7
    cmd(3, 7);
    idle();
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 0, 0);
    check_eq("midrun_rst_count", 32'(bus.count), 0);
    check_eq("midrun_rst_busy", 32'(bus.busy), 0);
    check_eq("midrun_rst_done", 32'(bus.done), 0);
    idle();
    check_eq("ready_rel", 32'(bus.cmd_ready), 1);
    idle();
    check_eq("no_late_done", 32'(bus.done), 0);

    // LOAD 7, UP 5 -> 8 9 0 1 2
    cmd(2, 7);
    check_eq("load7", 32'(bus.count), 7);
    cmd(3, 5);
    check_eq("up_first", 32'(bus.count), 8);
    for (int i = 0; i < 4; i++) begin
      idle();
      check_eq("up_seq_cnt", 32'(bus.count), exp_cnt[i]);
      check_eq("up_seq_tc", 32'(bus.tc), exp_tc[i]);
      check_eq("up_seq_done", 32'(bus.done), exp_done[i]);
    end
    idle();
    check_eq("up_busy_after", 32'(bus.busy), 0);

    // LOAD 1, DOWN 3 -> 0 9 8; then clamp
    cmd(2, 1);
    cmd(4, 3);
    check_eq("dn_0", 32'(bus.count), 0);
    idle();
    check_eq("dn_9", 32'(bus.count), 9);
    check_eq("dn_tc", 32'(bus.tc), 1);
    idle();
    check_eq("dn_8", 32'(bus.count), 8);
    check_eq("dn_done", 32'(bus.done), 1);
    cmd(2, 12);
    check_eq("load_clamp", 32'(bus.count), 9);

    // UP 9, STOP after the third step
    cmd(1, 0);
    cmd(3, 9);
    idle();
    idle();
    check_eq("pre_stop", 32'(bus.count), 3);
    cmd(5, 0);
    check_eq("stop_count", 32'(bus.count), 3);
    check_eq("stop_done", 32'(bus.done), 1);
    check_eq("stop_busy", 32'(bus.busy), 0);
    idle();

    // LOAD while busy is rejected and the run continues
    cmd(3, 9);
    cmd(2, 0);
    check_eq("busy_load_err", 32'(bus.cmd_err), 1);
    check_eq("busy_load_cnt", 32'(bus.count), 5);
    cmd(1, 0);
    check_eq("busy_clear", 32'(bus.count), 0);
    idle();

    // UP 0 and reserved op in IDLE
    cmd(3, 0);
    check_eq("up0_done", 32'(bus.done), 1);
    check_eq("up0_count", 32'(bus.count), 0);
    cmd(6, 3);
    check_eq("resv_err", 32'(bus.cmd_err), 1);
    check_eq("resv_count", 32'(bus.count), 0);
    idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit rst_r, v_r;
      int op_r, data_r;
      rst_r  = ($urandom_range(0, 59) == 0);
      v_r    = ($urandom_range(0, 2) == 0);
      op_r   = $urandom_range(0, 7);
      data_r = $urandom_range(0, 15);
      apply(rst_r, v_r, op_r, data_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
